// File: rtl/hac_star_serial_ctrl.sv
// Bit-serial sequencer around one HAC* cell (z = ~x ^ y, c = x | y).
// Operand bits enter the cell LSB-first; the cell's carry is registered between bits.
module hac_star_serial_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x_in,
  input  logic         cin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] z_out,
  output logic         cout
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   xsh;
  logic [N-1:0]   acc;
  logic [N-1:0]   acc_nxt;
  logic           creg;
  logic [CW-1:0]  cnt;
  logic           cell_z;
  logic           cell_c;
  logic           last_bit;

  // The HAC* cell: x is the current operand bit, y is the registered carry.
  assign cell_z   = ~xsh[0] ^ creg;
  assign cell_c   = xsh[0] | creg;
  assign last_bit = (cnt == CW'(N - 1));

  // The result assembles MSB-side so bit 0 lands at position 0 after N shifts.
  generate
    if (N == 1) begin : g_acc_single
      assign acc_nxt = cell_z;
    end else begin : g_acc_shift
      assign acc_nxt = {cell_z, acc[N-1:1]};
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xsh   <= '0;
      acc   <= '0;
      creg  <= 1'b0;
      cnt   <= '0;
      z_out <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            xsh  <= x_in;
            creg <= cin;
            cnt  <= '0;
            acc  <= '0;
          end
        end
        S_RUN: begin
          creg <= cell_c;
          acc  <= acc_nxt;
          xsh  <= xsh >> 1;
          cnt  <= cnt + CW'(1);
          // Publish on the edge that consumes the last bit; outputs hold otherwise.
          if (last_bit) begin
            z_out <= acc_nxt;
            cout  <= cell_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hac_star_serial_ctrl.sv
// Self-checking bench for hac_star_serial_ctrl (N=8) against a closed-form
// model: carry into bit i is cin OR any lower operand bit set.
module tb_hac_star_serial_ctrl;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] x_in;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] z_out;
  logic         cout;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] last_z;
  logic         last_c;

  hac_star_serial_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x_in  (x_in),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .z_out (z_out),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {cout, z}.
  function automatic logic [N:0] ref_op(input logic [N-1:0] x, input logic c);
    logic [N-1:0] z;
    logic [N-1:0] lower;
    logic         ci;
    for (int i = 0; i < N; i++) begin
      lower = x & N'((1 << i) - 1);
      ci    = c | (lower != '0);
      z[i]  = ~(x[i] ^ ci);
    end
    return {c | (x != '0), z};
  endfunction

  // Called #1 after an edge with the DUT idle. Optionally toggles start
  // randomly while the operation is in flight.
  task automatic run_op(input logic [N-1:0] x, input logic c, input bit noisy, input string tag);
    logic [N:0] exp;
    int         cycles;
    exp   = ref_op(x, c);
    start = 1'b1;
    x_in  = x;
    cin   = c;
    @(posedge clk); #1;
    start  = noisy ? 1'($urandom) : 1'b0;
    x_in   = N'($urandom);
    cin    = 1'($urandom);
    cycles = 0;
    check({tag, "_busy"}, {30'd0, busy, ready}, 32'b10);
    while (!done && cycles < 20) begin
      if (z_out !== last_z || cout !== last_c) begin
        check({tag, "_hold"}, {23'd0, cout, z_out}, {23'd0, last_c, last_z});
      end
      @(posedge clk); #1;
      cycles++;
      if (noisy) start = 1'($urandom);
    end
    check({tag, "_lat"}, cycles, N);
    check({tag, "_z"}, z_out, exp[N-1:0]);
    check({tag, "_cout"}, cout, exp[N]);
    start = noisy ? 1'b1 : 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_pulse"}, {30'd0, done, ready}, 32'b01);
    @(posedge clk); #1;
    check({tag, "_idle"}, {22'd0, ready, busy, cout, z_out}, {22'd0, 1'b1, 1'b0, exp[N], exp[N-1:0]});
    last_z = exp[N-1:0];
    last_c = exp[N];
  endtask

  initial begin
    logic [N-1:0] xs[30];
    logic         cs[30];
    logic [N:0]   e;

    rst    = 1'b1;
    start  = 1'b0;
    x_in   = '0;
    cin    = 1'b0;
    last_z = '0;
    last_c = 1'b0;
    #12;
    check("reset", {27'd0, ready, busy, done, cout, z_out != '0}, 32'b10000);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'h00, 1'b0, 0, "x00c0");

    // Asynchronous reset in the middle of a run.
    start = 1'b1; x_in = 8'h5A; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst", {22'd0, ready, busy, done, cout, z_out}, {22'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    #1 rst = 1'b0;
    last_z = '0;
    last_c = 1'b0;
    @(posedge clk); #1;

    run_op(8'h00, 1'b1, 0, "x00c1");
    run_op(8'h04, 1'b0, 0, "x04c0");
    run_op(8'h80, 1'b0, 0, "x80c0");
    run_op(8'hFF, 1'b0, 1, "xFFc0");

    for (int k = 0; k < 12; k++) begin
      run_op(N'($urandom), 1'($urandom), bit'($urandom), "rand");
    end

    // start held high: a new operation every N+2 cycles.
    for (int i = 0; i < 30; i++) begin
      xs[i] = N'($urandom);
      cs[i] = 1'($urandom);
      start = 1'b1;
      x_in  = xs[i];
      cin   = cs[i];
      @(posedge clk); #1;
      check("b2b_ready", ready, (i % 10) == 9);
      check("b2b_done", done, (i % 10) == 8);
      if ((i % 10) == 8) begin
        e = ref_op(xs[i-8], cs[i-8]);
        check("b2b_z", z_out, e[N-1:0]);
        check("b2b_cout", cout, e[N]);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("end_idle", {30'd0, ready, busy}, 32'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
